// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the sequential radix-2 restoring divider:
// datapath width, FSM state encoding and the request bus layout.
`ifndef DIV_SEQ_CTRL_PKG_SV
`define DIV_SEQ_CTRL_PKG_SV

`define DIV_WIDTH 32
`define DIV_REQ_BUS_WD (2 + 2 * `DIV_WIDTH)

package div_seq_ctrl_pkg;

  localparam int unsigned DIV_WIDTH = `DIV_WIDTH;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  // Request payload as carried from the EXM stage ({is_unsigned, use_mod, src1, src2})
  typedef struct packed {
    logic                 is_unsigned;
    logic                 use_mod;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
  } div_req_t;

endpackage

`endif

// File: rtl/div_iter_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, subtract the divisor if it fits, emit the quotient bit.
module div_iter_step
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt_c,
  output logic [WIDTH-1:0] quo_nxt_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  // rem < divisor holds between steps, so the WIDTH+1 bit trial never wraps
  // and its MSB is a true sign bit.
  always_comb begin
    shifted   = {rem, quo[WIDTH-1]};
    trial     = shifted - {1'b0, divisor};
    fits      = ~trial[WIDTH];
    rem_nxt_c = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt_c = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencing controller for the EXM-stage multi-cycle signed/unsigned divider.
// Optional DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             is_unsigned,
  input  logic             use_mod,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  div_state_t       state_q, state_d;

  logic             unsigned_q, unsigned_d;
  logic             mod_q, mod_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH-1:0] step_rem, step_quo;

  div_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_nxt_c(step_rem),
    .quo_nxt_c(step_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath next values
  always_comb begin
    state_d    = state_q;
    unsigned_d = unsigned_q;
    mod_d      = mod_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    result_d   = result;

    dvd_neg = ~unsigned_q & dvd_q[WIDTH-1];
    dvs_neg = ~unsigned_q & dvs_q[WIDTH-1];
    dvd_mag = dvd_neg ? (~dvd_q + WIDTH'(1)) : dvd_q;
    dvs_mag = dvs_neg ? (~dvs_q + WIDTH'(1)) : dvs_q;
    quo_fix = (q_neg_q && (dvs_q != '0)) ? (~quo_q + WIDTH'(1)) : quo_q;
    rem_fix = r_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;

    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          unsigned_d = is_unsigned;
          mod_d      = use_mod;
          dvd_d      = dividend;
          dvs_d      = divisor;
          state_d    = PREP;
        end
      end
      PREP: begin
        q_neg_d = dvd_neg ^ dvs_neg;
        r_neg_d = dvd_neg;
        dvs_d   = dvs_mag;
        rem_d   = '0;
        quo_d   = dvd_mag;
        cnt_d   = CNT_W'(WIDTH - 1);
        if (dvs_q == '0) begin
          quo_d   = '1;
          rem_d   = dvd_mag;
          state_d = FIX;
`ifdef DIV_EARLY_OUT_EN
        end else if (dvd_mag < dvs_mag) begin
          quo_d   = '0;
          rem_d   = dvd_mag;
          state_d = FIX;
`endif
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      FIX: begin
        result_d = mod_q ? rem_fix : quo_fix;
        state_d  = DONE;
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush (branch mispredict) wins over everything, including resp_ready
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      unsigned_q <= 1'b0;
      mod_q      <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      result     <= '0;
    end else begin
      unsigned_q <= unsigned_d;
      mod_q      <= mod_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      result     <= result_d;
    end
  end

  // Handshake outputs registered from the next state so they track state_q exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      req_ready  <= (state_d == IDLE);
      resp_valid <= (state_d == DONE);
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: directed corner cases, flush/reset/backpressure,
// then randomized operands against an arithmetic reference model.
module tb_div_seq_ctrl;

  localparam int unsigned W = 32;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         req_valid;
  logic         req_ready;
  logic         is_unsigned;
  logic         use_mod;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] result;
  logic         busy;

  logic rr_dir  = 1'b1;
  logic rr_rand = 1'b1;
  logic rand_rr = 1'b0;
  assign resp_ready = rand_rr ? rr_rand : rr_dir;

  div_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_unsigned(is_unsigned),
    .use_mod    (use_mod),
    .dividend   (dividend),
    .divisor    (divisor),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  always @(negedge clk) rr_rand = ($urandom % 4) != 0;

  typedef struct {
    logic [W-1:0] res;
    int           acc;
    int           lat;
  } exp_t;

  exp_t scb[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail_msg(input string nm);
    n_tot++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic logic [W-1:0] mag(input logic uns, input logic [W-1:0] x);
    if (!uns && x[W-1]) return W'(0) - x;
    return x;
  endfunction

  // Reference: RISC-V style DIV/DIVU/REM/REMU semantics
  function automatic logic [W-1:0] ref_res(input logic uns, input logic md,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sbv;
    sa  = a;
    sbv = b;
    if (b == 0) return md ? a : '1;
    if (uns) return md ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return md ? '0 : a;
    return md ? W'(sa % sbv) : W'(sa / sbv);
  endfunction

  function automatic int ref_lat(input logic uns, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return 2;
    if (EARLY && (mag(uns, a) < mag(uns, b))) return 2;
    return W + 2;
  endfunction

  task automatic issue(input logic uns, input logic md, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int t;
    exp_t e;
    @(negedge clk);
    is_unsigned = uns;
    use_mod     = md;
    dividend    = a;
    divisor     = b;
    req_valid   = 1'b1;
    t = 0;
    while (!req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      fail_msg("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.res = ref_res(uns, md, a, b);
    e.acc = cyc;
    e.lat = ref_lat(uns, a, b);
    scb.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((scb.size() != 0 || !req_ready) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (scb.size() != 0 || !req_ready) fail_msg("drain_timeout");
  endtask

  // Monitor: each rising resp_valid consumes one scoreboard entry
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid && !prev_v) begin
      if (scb.size() == 0) begin
        fail_msg("unexpected_resp");
      end else begin
        e = scb.pop_front();
        chk("result", result, e.res);
        chk("latency", W'(cyc - e.acc), W'(e.lat));
      end
    end
    prev_v = resp_valid;
  end

  initial begin
    int t;
    logic [W-1:0] a, b;
    exp_t dropped;

    reset       = 1'b1;
    flush       = 1'b0;
    req_valid   = 1'b0;
    is_unsigned = 1'b0;
    use_mod     = 1'b0;
    dividend    = '0;
    divisor     = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_resp_valid", W'(resp_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_result", result, '0);
    reset = 1'b0;

    // Directed arithmetic and boundary cases
    issue(1'b1, 1'b0, 32'd100, 32'd7);
    issue(1'b1, 1'b1, 32'd100, 32'd7);
    issue(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2);
    issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    issue(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(1'b1, 1'b0, 32'h0000_1234, 32'd0);
    issue(1'b1, 1'b1, 32'h0000_1234, 32'd0);
    issue(1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0);
    issue(1'b1, 1'b0, 32'd3, 32'd10);
    issue(1'b1, 1'b1, 32'd3, 32'd10);
    issue(1'b1, 1'b0, 32'd3, 32'd0);
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();

    // Flush during ITER discards the operation
    issue(1'b1, 1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    dropped = scb.pop_back();
    chk("flush_req_ready", W'(req_ready), W'(1));
    chk("flush_busy", W'(busy), W'(0));
    chk("flush_resp_valid", W'(resp_valid), W'(0));
    repeat (40) @(negedge clk);
    issue(1'b1, 1'b0, 32'd9, 32'd3);
    drain();

    // Flush coincident with a request: not accepted
    @(negedge clk);
    is_unsigned = 1'b1;
    use_mod     = 1'b0;
    dividend    = 32'd50;
    divisor     = 32'd5;
    req_valid   = 1'b1;
    flush       = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    chk("flush_req_busy", W'(busy), W'(0));
    chk("flush_req_ready", W'(req_ready), W'(1));
    repeat (3) @(negedge clk);
    chk("flush_req_busy_later", W'(busy), W'(0));

    // Backpressure in DONE holds the result
    rr_dir = 1'b0;
    issue(1'b1, 1'b0, 32'd100, 32'd7);
    t = 0;
    while (!resp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!resp_valid) fail_msg("bp_resp_timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", W'(resp_valid), W'(1));
      chk("bp_result", result, 32'd14);
      chk("bp_req_ready", W'(req_ready), W'(0));
    end
    rr_dir = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", W'(resp_valid), W'(0));
    chk("bp_release_ready", W'(req_ready), W'(1));

    // Reset in the middle of ITER
    issue(1'b0, 1'b0, 32'd12345, 32'hFFFF_FFEF);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dropped = scb.pop_back();
    chk("midrst_req_ready", W'(req_ready), W'(1));
    chk("midrst_resp_valid", W'(resp_valid), W'(0));
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_result", result, '0);
    reset = 1'b0;
    issue(1'b0, 1'b1, 32'd12345, 32'hFFFF_FFEF);
    drain();

    // Randomized operands with random consumer backpressure
    rand_rr = 1'b1;
    for (int n = 0; n < 300; n++) begin
      case ($urandom % 6)
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 40));
        2:       a = 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
        default: a = $urandom;
      endcase
      case ($urandom % 8)
        0:       b = '0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'h8000_0000;
        4:       b = $urandom >> ($urandom % 32);
        default: b = $urandom;
      endcase
      issue(1'($urandom % 2), 1'($urandom % 2), a, b);
    end
    drain();
    rand_rr = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
